bcd_digit_feeder: RTL and testbench
===================================

# bcd_digit_feeder

Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment controller. It accepts a 14-bit unsigned value on a start pulse and runs an iterative double-dabble (shift/add-3) conversion, one bit per clock. When conversion completes it presents four registered BCD digits plus a leading-zero-blanking enable mask, which wire straight to the controller's digit0..digit3 and mode inputs.

## Interface
- LZ_BLANK, 1, 1: generate leading-zero-blanking mask on mode; 0: mode is always 4'b1111
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a conversion; sampled only in IDLE
- bin  in  14  unsigned binary value, captured at the edge where start is accepted
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse; outputs updated
- ovf  out  1  last converted value exceeded 9999
- digit0  out  4  BCD ones
- digit1  out  4  BCD tens
- digit2  out  4  BCD hundreds
- digit3  out  4  BCD thousands
- mode  out  4  per-digit enable mask, bit n enables digitn

## Operation
- States:
  - IDLE: on start=1, load the 30-bit shift register {16'b0, bin}, clear the step counter, latch ovf_pend = (bin > 14'd9999), and go to CONV.
  - CONV: each cycle, every BCD nibble >= 5 gets +3, then the whole register shifts left 1. Step counter increments. On step 13 (the 14th shift), go to IDLE and update the outputs.
- Output update at the final edge:
  - If ovf_pend = 0: digitN = BCD nibble N, and ovf = 0.
  - If ovf_pend = 1: all digits = 4'hF, mode = 4'b1111, and ovf = 1.
- mode when LZ_BLANK = 1 and not overflowing:
  - mode[0] = 1
  - mode[1] = (digit3|digit2|digit1) != 0
  - mode[2] = (digit3|digit2) != 0
  - mode[3] = digit3 != 0
- digit*, mode and ovf hold their values between conversions. They never change during CONV.
- start while busy is ignored. No queuing, no effect on the running conversion.
- bin changes after the capture edge have no effect.

## Timing
- Reset values:
  - busy = 0, done = 0, ovf = 0
  - all digits = 4'h0
  - mode = 4'b0001 (LZ_BLANK = 1) or 4'b1111 (LZ_BLANK = 0)
  - state = IDLE
- Cycle sequence:
  - start sampled high at edge E0 → busy = 1 after E0.
  - Shifts occur at edges E1..E14.
  - At E14: outputs load, done = 1, busy = 0.
  - At E15: done = 0.
- Latency: 14 clocks from the start-sampling edge to done. busy is high for exactly 14 cycles.
- Throughput:
  - The earliest next start is sampled at E15, during the done-high cycle. That start is accepted.
  - Back-to-back conversion period is 15 clocks.
- start held continuously high: a new conversion begins every 15 clocks.
- rst asserted mid-CONV: immediate abort, all outputs take reset values, and no done pulse is produced.
- Boundary conditions:
  - bin = 0 → digits 0,0,0,0.
  - bin = 9999 → 9,9,9,9 with ovf = 0.
  - bin = 10000..16383 → overflow path. Upper BCD bits lost in the 16-bit BCD field are irrelevant.
- Internal width: 16-bit BCD field plus 14-bit binary field, 4-bit step counter. No truncation except overflow-path BCD bits.

## Test plan
- Reset, then start with bin = 1234 → done exactly 14 clocks after the sampled start; digit3..0 = 1,2,3,4; mode = 1111; ovf = 0; busy high for 14 cycles.
- bin = 7, then bin = 0, with LZ_BLANK = 1 → 0,0,0,7 / mode = 0001, then 0,0,0,0 / mode = 0001. With LZ_BLANK = 0 → mode = 1111 for both.
- bin = 9999 → 9,9,9,9, ovf = 0. bin = 10000 → F,F,F,F, mode = 1111, ovf = 1. A following bin = 50 → 0,0,5,0, mode = 0011, ovf = 0.
- Start with bin = 305, then pulse start with bin = 42 at cycle 5 of CONV → single done; result 0,3,0,5. Second start ignored.
- start held high with bin = 100 → done pulses every 15 clocks, each one cycle wide.
- Assert rst at cycle 8 of a conversion of bin = 8888 → outputs at reset values immediately. No done pulse. The next start with bin = 21 → 0,0,2,1 after 14 cycles.

Source files
------------

// File: rtl/bcd_digit_feeder.sv
// ---------------------------------------------------------------------------
// bcd_digit_feeder
//
// Iterative double-dabble (shift / add-3) binary-to-BCD converter feeding a
// 4-digit seven-segment controller. A 14-bit value is captured on an accepted
// start and converted one bit per clock (14 clocks). On completion the four
// BCD digits, a leading-zero-blanking enable mask and an overflow flag are
// registered and held until the next completed conversion.
//
// Handshake: start is a level request looked at only while idle. The cycle
// after acceptance busy is high for exactly 14 cycles; done is a one-cycle
// pulse in the cycle after the last shift, coincident with the new outputs.
// A start seen while busy is dropped, and bin is don't-care after capture.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   start        in   conversion request (idle only)
//   bin[13:0]    in   unsigned binary value, captured with start
//   busy         out  conversion in progress
//   done         out  one-cycle completion pulse
//   ovf          out  last converted value exceeded 9999
//   digit0..3    out  BCD ones / tens / hundreds / thousands
//   mode[3:0]    out  per-digit enable mask (bit n enables digitn)
//   state_dbg_o  out  FSM state (0 = IDLE, 1 = CONV)
//
// Parameter
//   LZ_BLANK     1: mode blanks leading zeros, 0: mode is always 4'b1111
// ---------------------------------------------------------------------------
module bcd_digit_feeder #(
   parameter bit LZ_BLANK = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [13:0] bin,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [3:0]  digit0,
   output logic [3:0]  digit1,
   output logic [3:0]  digit2,
   output logic [3:0]  digit3,
   output logic [3:0]  mode,
   output logic        state_dbg_o
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_CONV = 1'b1
   } state_t;

   localparam logic [3:0] MODE_RST   = LZ_BLANK ? 4'b0001 : 4'b1111;
   localparam logic [3:0] LAST_STEP  = 4'd13;
   localparam logic [13:0] MAX_VALUE = 14'd9999;

   state_t       state_q, state_d;

   // {BCD thousands..ones [29:14], binary remainder [13:0]}
   logic [29:0]  shreg_q;
   logic [3:0]   step_q;
   logic         ovf_pend_q;

   logic         done_q;
   logic         ovf_q;
   logic [3:0]   digit0_q, digit1_q, digit2_q, digit3_q;
   logic [3:0]   mode_q;

   logic         accept;
   logic         finish;
   logic         conv_active;

   logic [29:0]  adj;
   logic [29:0]  shifted;
   logic [15:0]  bcd_final;
   logic [3:0]   mode_new;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_CONV;
         S_CONV:  if (step_q == LAST_STEP) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output / control decode
   // ------------------------------------------------------------------
   always_comb begin
      conv_active = (state_q == S_CONV);
      accept      = (state_q == S_IDLE) && start;
      finish      = (state_q == S_CONV) && (step_q == LAST_STEP);
   end

   // ------------------------------------------------------------------
   // Double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
   // ------------------------------------------------------------------
   always_comb begin
      adj = shreg_q;
      for (int i = 0; i < 4; i++) begin
         if (shreg_q[14 + 4*i +: 4] >= 4'd5) begin
            adj[14 + 4*i +: 4] = shreg_q[14 + 4*i +: 4] + 4'd3;
         end
      end
      shifted   = {adj[28:0], 1'b0};
      bcd_final = shifted[29:14];
   end

   // Blanking mask for the digits produced by the final shift.
   always_comb begin
      mode_new = 4'b1111;
      if (LZ_BLANK) begin
         mode_new[0] = 1'b1;
         mode_new[1] = (bcd_final[15:12] | bcd_final[11:8] | bcd_final[7:4]) != 4'd0;
         mode_new[2] = (bcd_final[15:12] | bcd_final[11:8]) != 4'd0;
         mode_new[3] = bcd_final[15:12] != 4'd0;
      end
   end

   // ------------------------------------------------------------------
   // Conversion datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q    <= '0;
         step_q     <= '0;
         ovf_pend_q <= 1'b0;
      end else if (accept) begin
         shreg_q    <= {16'b0, bin};
         step_q     <= '0;
         ovf_pend_q <= (bin > MAX_VALUE);
      end else if (conv_active) begin
         shreg_q    <= shifted;
         step_q     <= step_q + 4'd1;
      end
   end

   // ------------------------------------------------------------------
   // Result registers: only written on the final conversion edge.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         digit0_q <= 4'h0;
         digit1_q <= 4'h0;
         digit2_q <= 4'h0;
         digit3_q <= 4'h0;
         mode_q   <= MODE_RST;
      end else begin
         done_q <= finish;
         if (finish) begin
            if (ovf_pend_q) begin
               // Over-range: show all-F on every digit, BCD bits discarded.
               ovf_q    <= 1'b1;
               digit0_q <= 4'hF;
               digit1_q <= 4'hF;
               digit2_q <= 4'hF;
               digit3_q <= 4'hF;
               mode_q   <= 4'b1111;
            end else begin
               ovf_q    <= 1'b0;
               digit0_q <= bcd_final[3:0];
               digit1_q <= bcd_final[7:4];
               digit2_q <= bcd_final[11:8];
               digit3_q <= bcd_final[15:12];
               mode_q   <= mode_new;
            end
         end
      end
   end

   assign busy        = conv_active;
   assign done        = done_q;
   assign ovf         = ovf_q;
   assign digit0      = digit0_q;
   assign digit1      = digit1_q;
   assign digit2      = digit2_q;
   assign digit3      = digit3_q;
   assign mode        = mode_q;
   assign state_dbg_o = (state_q == S_CONV);

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_feeder
//
// Directed bench for bcd_digit_feeder. Two instances share all inputs: one
// with leading-zero blanking, one without, so both mode behaviours are seen
// on every conversion. Expected digits/masks are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_bcd_digit_feeder;

   logic        clk;
   logic        rst;
   logic        start;
   logic [13:0] bin;

   logic        busy1, done1, ovf1, st1;
   logic [3:0]  d0_1, d1_1, d2_1, d3_1, mode1;
   logic        busy0, done0, ovf0, st0;
   logic [3:0]  d0_0, d1_0, d2_0, d3_0, mode0;

   int checks = 0;
   int errors = 0;

   bcd_digit_feeder #(.LZ_BLANK(1'b1)) dut_lz (
      .clk(clk), .rst(rst), .start(start), .bin(bin),
      .busy(busy1), .done(done1), .ovf(ovf1),
      .digit0(d0_1), .digit1(d1_1), .digit2(d2_1), .digit3(d3_1),
      .mode(mode1), .state_dbg_o(st1)
   );

   bcd_digit_feeder #(.LZ_BLANK(1'b0)) dut_nolz (
      .clk(clk), .rst(rst), .start(start), .bin(bin),
      .busy(busy0), .done(done0), .ovf(ovf0),
      .digit0(d0_0), .digit1(d1_0), .digit2(d2_0), .digit3(d3_0),
      .mode(mode0), .state_dbg_o(st0)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " busy"},  {30'd0, busy1, busy0}, 32'd0);
      chk({tag, " done"},  {30'd0, done1, done0}, 32'd0);
      chk({tag, " ovf"},   {30'd0, ovf1, ovf0},   32'd0);
      chk({tag, " state"}, {30'd0, st1, st0},     32'd0);
      chk({tag, " digits"}, {d3_1, d2_1, d1_1, d0_1, d3_0, d2_0, d1_0, d0_0}, 32'd0);
      chk({tag, " mode_lz"},   {28'd0, mode1}, 32'h1);
      chk({tag, " mode_nolz"}, {28'd0, mode0}, 32'hF);
   endtask

   task automatic chk_out(input string tag, input logic [15:0] dig,
                          input logic [3:0] m, input logic o);
      chk({tag, " digits_lz"},   {16'd0, d3_1, d2_1, d1_1, d0_1}, {16'd0, dig});
      chk({tag, " digits_nolz"}, {16'd0, d3_0, d2_0, d1_0, d0_0}, {16'd0, dig});
      chk({tag, " mode_lz"},     {28'd0, mode1}, {28'd0, m});
      chk({tag, " mode_nolz"},   {28'd0, mode0}, 32'hF);
      chk({tag, " ovf"},         {30'd0, ovf1, ovf0}, {30'd0, o, o});
   endtask

   // Start a conversion now (one cycle after a posedge), wait for done with a
   // bounded loop and check latency, busy length and one-cycle done width.
   // Returns just after the done edge, so a following call starts at E15.
   task automatic do_conv(input string tag, input logic [13:0] v);
      int n;
      int busy_n;
      start = 1'b1;
      bin   = v;
      @(posedge clk); #1;               // E0 sampled
      start = 1'b0;
      bin   = 14'($urandom_range(0, 16383));
      chk({tag, " done_low_after_start"}, {31'd0, done1}, 32'd0);
      n = 0;
      busy_n = 0;
      while (!done1 && n < 30) begin
         if (busy1) busy_n++;
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"},   n,      32'd14);
      chk({tag, " busy_len"},  busy_n, 32'd14);
      chk({tag, " busy_at_done"}, {30'd0, busy1, busy0}, 32'd0);
      chk({tag, " done_nolz"}, {31'd0, done0}, 32'd1);
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int dn;
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      rst = 1'b0;
      idle_cycle();
      chk_reset("after_reset_release");

      // Basic conversion.
      do_conv("c1234", 14'd1234);
      chk_out("c1234", 16'h1234, 4'b1111, 1'b0);
      idle_cycle();
      chk("c1234 done_one_cycle", {31'd0, done1}, 32'd0);
      chk_out("c1234_hold", 16'h1234, 4'b1111, 1'b0);

      // Leading-zero blanking.
      do_conv("c7", 14'd7);
      chk_out("c7", 16'h0007, 4'b0001, 1'b0);
      do_conv("c0", 14'd0);
      chk_out("c0", 16'h0000, 4'b0001, 1'b0);

      // Range boundaries.
      do_conv("c9999", 14'd9999);
      chk_out("c9999", 16'h9999, 4'b1111, 1'b0);
      do_conv("c10000", 14'd10000);
      chk_out("c10000", 16'hFFFF, 4'b1111, 1'b1);
      do_conv("c50", 14'd50);
      chk_out("c50", 16'h0050, 4'b0011, 1'b0);
      do_conv("c16383", 14'd16383);
      chk_out("c16383", 16'hFFFF, 4'b1111, 1'b1);
      do_conv("c908", 14'd908);
      chk_out("c908", 16'h0908, 4'b0111, 1'b0);
      idle_cycle();

      // Start during CONV is ignored.
      start = 1'b1;
      bin   = 14'd305;
      @(posedge clk); #1;
      start = 1'b0;
      n  = 0;
      dn = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         start = (n == 5);
         bin   = (n == 5) ? 14'd42 : 14'd305;
         if (done1) begin
            dn++;
            chk("overlap done_cycle", n, 32'd14);
            chk_out("overlap", 16'h0305, 4'b0111, 1'b0);
         end
      end
      chk("overlap done_count", dn, 32'd1);
      chk_out("overlap_hold", 16'h0305, 4'b0111, 1'b0);

      // start held high: one conversion every 15 clocks.
      start = 1'b1;
      bin   = 14'd100;
      @(posedge clk); #1;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk); #1;
         chk($sformatf("held done@%0d", k), {31'd0, done1},
             {31'd0, (k == 14 || k == 29 || k == 44)});
      end
      start = 1'b0;
      n = 0;
      while (!done1 && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      chk("held last_done", n, 32'd14);
      chk_out("held", 16'h0100, 4'b0111, 1'b0);
      idle_cycle();

      // Reset in the middle of a conversion.
      start = 1'b1;
      bin   = 14'd8888;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("midrst busy_before", {31'd0, busy1}, 32'd1);
      rst = 1'b1;
      #1;
      chk_reset("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      dn = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (done1 || done0) dn++;
      end
      chk("midrst no_done", dn, 32'd0);
      chk_reset("midrst_idle");

      do_conv("c21", 14'd21);
      chk_out("c21", 16'h0021, 4'b0011, 1'b0);
      idle_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
